riscv_timer_ctrl: RTL and testbench

RISCV_TIMER_CTRL -- requirements
Module: riscv_timer_ctrl

---
 rtl/riscv_timer_pkg.sv | 33 +++
 rtl/riscv_counter.sv | 41 ++++
 rtl/riscv_timer_ctrl.sv | 161 ++++++++++++++++
 tb/tb_riscv_timer_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_timer_pkg.sv
// Shared definitions for the machine timer block.
//   - Register byte offsets of the request interface
//   - CTRL bit index of the enable
//   - Write-staging FSM state and staging target encodings
//   - Reset value of the compare register and prescaler count width
package riscv_timer_pkg;

    localparam logic [4:0] ADDR_MTIME_LO = 5'h00;
    localparam logic [4:0] ADDR_MTIME_HI = 5'h04;
    localparam logic [4:0] ADDR_CMP_LO   = 5'h08;
    localparam logic [4:0] ADDR_CMP_HI   = 5'h0C;
    localparam logic [4:0] ADDR_CTRL     = 5'h10;

    localparam int CTRL_EN_BIT = 0;

    // Compare resets to all ones so the interrupt cannot fire before software
    // programs a deadline.
    localparam logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    // Wide enough for PRESCALE up to 256 (count runs 0..PRESCALE-1).
    localparam int PRESCALE_W = 8;

    typedef enum logic {
        ST_IDLE,
        ST_STAGED
    } wr_state_e;

    typedef enum logic {
        TGT_MTIME,
        TGT_CMP
    } wr_target_e;

endpackage

// File: rtl/riscv_counter.sv
// 64-bit mtime storage register.
//   clk      : clock
//   rst      : asynchronous reset, active high
//   write_en : load wdata (wins over increment)
//   wdata    : value to load
//   incr_en  : add one, wrapping from 2^64-1 to 0
//   count    : current value
module riscv_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_en,
    input  logic [63:0] wdata,
    input  logic        incr_en,
    output logic [63:0] count
);

    logic [63:0] count_d;
    logic [63:0] count_q;

    always_comb begin
        // NOTE: default first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        if (write_en) begin
            count_d = wdata;
        end else if (incr_en) begin
            count_d = count_q + 64'd1;
        end
    end

    // NOTE: non-blocking assignments for flops so all state updates see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/riscv_timer_ctrl.sv
// RISC-V machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp, level
// interrupt, and a 32-bit register port with atomic LO/HI write staging and a
// HI snapshot for tear-free 64-bit reads.
//   clk       : clock
//   rst       : asynchronous reset, active low
//   req_*     : single-cycle register request (valid, write enable, byte offset, data)
//   rsp_*     : response one cycle after every request (valid, read data)
//   mtime     : current counter value
//   timer_irq : registered EN && (mtime >= mtimecmp)
module riscv_timer_ctrl
    import riscv_timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [4:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [63:0] mtime,
    output logic        timer_irq
);

    localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(PRESCALE - 1);

    wr_state_e              state_d,     state_q;
    wr_target_e             target_d,    target_q;
    logic [31:0]            shadow_lo_d, shadow_lo_q;
    logic [31:0]            snapshot_d,  snapshot_q;
    logic [63:0]            cmp_d,       cmp_q;
    logic                   en_d,        en_q;
    logic [PRESCALE_W-1:0]  presc_d,     presc_q;
    logic                   rsp_valid_d, rsp_valid_q;
    logic [31:0]            rdata_d,     rdata_q;
    logic                   irq_d,       irq_q;

    logic                   staged_hit;
    logic                   mtime_wr_en;
    logic [63:0]            mtime_wr_data;
    logic                   tick;

    riscv_counter u_counter (
        .clk      (clk),
        .rst      (!rst),
        .write_en (mtime_wr_en),
        .wdata    (mtime_wr_data),
        .incr_en  (tick),
        .count    (mtime)
    );

    // Only a HI write to the same register that was staged completes staging;
    // anything else aborts it and is then handled as an ordinary access.
    assign staged_hit = (state_q == ST_STAGED) && req_we &&
                        (((req_addr == ADDR_MTIME_HI) && (target_q == TGT_MTIME)) ||
                         ((req_addr == ADDR_CMP_HI)   && (target_q == TGT_CMP)));

    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        shadow_lo_d   = shadow_lo_q;
        snapshot_d    = snapshot_q;
        cmp_d         = cmp_q;
        en_d          = en_q;
        rdata_d       = '0;
        mtime_wr_en   = 1'b0;
        mtime_wr_data = '0;

        if (req_valid) begin
            state_d = ST_IDLE;
            if (staged_hit) begin
                if (target_q == TGT_CMP) begin
                    cmp_d = {req_wdata, shadow_lo_q};
                end else begin
                    mtime_wr_en   = 1'b1;
                    mtime_wr_data = {req_wdata, shadow_lo_q};
                end
            end else if (req_we) begin
                case (req_addr)
                    ADDR_MTIME_LO: begin
                        shadow_lo_d = req_wdata;
                        target_d    = TGT_MTIME;
                        state_d     = ST_STAGED;
                    end
                    ADDR_CMP_LO: begin
                        shadow_lo_d = req_wdata;
                        target_d    = TGT_CMP;
                        state_d     = ST_STAGED;
                    end
                    ADDR_MTIME_HI: begin
                        mtime_wr_en   = 1'b1;
                        mtime_wr_data = {req_wdata, mtime[31:0]};
                    end
                    ADDR_CMP_HI: cmp_d = {req_wdata, cmp_q[31:0]};
                    ADDR_CTRL:   en_d  = req_wdata[CTRL_EN_BIT];
                    default: ;
                endcase
            end else begin
                case (req_addr)
                    ADDR_MTIME_LO: begin
                        rdata_d    = mtime[31:0];
                        snapshot_d = mtime[63:32];
                    end
                    ADDR_MTIME_HI: rdata_d = snapshot_q;
                    ADDR_CMP_LO:   rdata_d = cmp_q[31:0];
                    ADDR_CMP_HI:   rdata_d = cmp_q[63:32];
                    ADDR_CTRL:     rdata_d[CTRL_EN_BIT] = en_q;
                    default: ;
                endcase
            end
        end
    end

    // Prescaler: one tick every PRESCALE enabled cycles. An mtime write clears
    // it and drops any coincident tick (the counter gives write priority).
    always_comb begin
        tick    = en_q && (presc_q == PRESC_LAST);
        presc_d = presc_q;
        if (mtime_wr_en) begin
            presc_d = '0;
        end else if (en_q) begin
            presc_d = tick ? '0 : presc_q + PRESCALE_W'(1);
        end
    end

    assign rsp_valid_d = req_valid;
    assign irq_d       = en_q && (mtime >= cmp_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            target_q    <= TGT_MTIME;
            shadow_lo_q <= '0;
            snapshot_q  <= '0;
            cmp_q       <= CMP_RESET;
            en_q        <= 1'b0;
            presc_q     <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            shadow_lo_q <= shadow_lo_d;
            snapshot_q  <= snapshot_d;
            cmp_q       <= cmp_d;
            en_q        <= en_d;
            presc_q     <= presc_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            irq_q       <= irq_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign timer_irq = irq_q;

endmodule

// File: tb/tb_riscv_timer_ctrl.sv
// Self-checking bench: two instances (PRESCALE = 1 and 4) share one request
// stream; each is compared every cycle against a register-level model of the
// timer, plus directed scenarios with fixed expected values.
module tb_riscv_timer_ctrl;
    import riscv_timer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;

    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata [2];
    logic [63:0] mtime_o   [2];
    logic [1:0]  irq;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state, one entry per instance.
    int          presc     [2] = '{1, 4};
    logic [63:0] m_time    [2];
    logic [63:0] m_cmp     [2];
    bit          m_en      [2];
    bit          m_staged  [2];
    bit          m_tgt_cmp [2];
    logic [31:0] m_lo      [2];
    logic [31:0] m_snap    [2];
    int          m_phase   [2];
    bit          m_irq     [2];
    logic [31:0] m_rdata   [2];

    always #5 clk = ~clk;

    riscv_timer_ctrl #(.PRESCALE(1)) dut_p1 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid[0]),
        .rsp_rdata (rsp_rdata[0]),
        .mtime     (mtime_o[0]),
        .timer_irq (irq[0])
    );

    riscv_timer_ctrl #(.PRESCALE(4)) dut_p4 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid[1]),
        .rsp_rdata (rsp_rdata[1]),
        .mtime     (mtime_o[1]),
        .timer_irq (irq[1])
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic model_reset(input int k);
        m_time[k]    = '0;
        m_cmp[k]     = 64'hFFFF_FFFF_FFFF_FFFF;
        m_en[k]      = 1'b0;
        m_staged[k]  = 1'b0;
        m_tgt_cmp[k] = 1'b0;
        m_lo[k]      = '0;
        m_snap[k]    = '0;
        m_phase[k]   = 0;
        m_irq[k]     = 1'b0;
        m_rdata[k]   = '0;
    endtask

    // One clock of the timer as seen from the register interface.
    task automatic model_step(input int k, input logic v, input logic we,
                              input logic [4:0] a, input logic [31:0] wd);
        logic [63:0] old_t;
        logic [63:0] old_c;
        bit          old_en;
        bit          wr_time;
        logic [63:0] new_t;
        bit          matched;
        old_t   = m_time[k];
        old_c   = m_cmp[k];
        old_en  = m_en[k];
        wr_time = 1'b0;
        new_t   = '0;
        m_irq[k]   = old_en && (old_t >= old_c);
        m_rdata[k] = '0;
        if (v) begin
            matched = m_staged[k] && we &&
                      ((a == ADDR_MTIME_HI && !m_tgt_cmp[k]) || (a == ADDR_CMP_HI && m_tgt_cmp[k]));
            m_staged[k] = 1'b0;
            if (matched) begin
                if (m_tgt_cmp[k]) m_cmp[k] = {wd, m_lo[k]};
                else begin wr_time = 1'b1; new_t = {wd, m_lo[k]}; end
            end else if (we) begin
                case (a)
                    ADDR_MTIME_LO: begin m_lo[k] = wd; m_tgt_cmp[k] = 1'b0; m_staged[k] = 1'b1; end
                    ADDR_CMP_LO:   begin m_lo[k] = wd; m_tgt_cmp[k] = 1'b1; m_staged[k] = 1'b1; end
                    ADDR_MTIME_HI: begin wr_time = 1'b1; new_t = {wd, old_t[31:0]}; end
                    ADDR_CMP_HI:   m_cmp[k] = {wd, old_c[31:0]};
                    ADDR_CTRL:     m_en[k] = wd[0];
                    default: ;
                endcase
            end else begin
                case (a)
                    ADDR_MTIME_LO: begin m_rdata[k] = old_t[31:0]; m_snap[k] = old_t[63:32]; end
                    ADDR_MTIME_HI: m_rdata[k] = m_snap[k];
                    ADDR_CMP_LO:   m_rdata[k] = old_c[31:0];
                    ADDR_CMP_HI:   m_rdata[k] = old_c[63:32];
                    ADDR_CTRL:     m_rdata[k] = {31'b0, old_en};
                    default: ;
                endcase
            end
        end
        if (wr_time) begin
            m_time[k]  = new_t;
            m_phase[k] = 0;
        end else if (old_en) begin
            if (m_phase[k] + 1 == presc[k]) begin
                m_time[k]  = old_t + 64'd1;
                m_phase[k] = 0;
            end else begin
                m_phase[k] = m_phase[k] + 1;
            end
        end
    endtask

    task automatic do_cycle(input logic v, input logic we, input logic [4:0] a, input logic [31:0] wd);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        for (int k = 0; k < 2; k++) model_step(k, v, we, a, wd);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("p%0d rsp_valid", presc[k]), 64'(rsp_valid[k]), 64'(v));
            if (v && !we)
                check($sformatf("p%0d rdata a=%0h", presc[k], a), 64'(rsp_rdata[k]), 64'(m_rdata[k]));
            check($sformatf("p%0d mtime", presc[k]), mtime_o[k], m_time[k]);
            check($sformatf("p%0d irq", presc[k]), 64'(irq[k]), 64'(m_irq[k]));
        end
        req_valid = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d); do_cycle(1'b1, 1'b1, a, d); endtask
    task automatic rd(input logic [4:0] a);                       do_cycle(1'b1, 1'b0, a, '0); endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req_valid = 1'b0;
        #2;
        for (int k = 0; k < 2; k++) begin
            model_reset(k);
            check($sformatf("p%0d reset mtime", presc[k]), mtime_o[k], 64'h0);
            check($sformatf("p%0d reset irq", presc[k]), 64'(irq[k]), 64'h0);
            check($sformatf("p%0d reset rsp_valid", presc[k]), 64'(rsp_valid[k]), 64'h0);
            check($sformatf("p%0d reset rdata", presc[k]), 64'(rsp_rdata[k]), 64'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit          found;
        logic [4:0]  a;
        logic [31:0] wd;
        bit          v;
        bit          we;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        #3;
        do_reset();

        // Prescaled counting after enabling.
        wr(ADDR_CTRL, 32'h1);
        idle(4);
        check("p4 mtime after 4 cycles", mtime_o[1], 64'd1);
        idle(96);
        check("p4 mtime after 100 cycles", mtime_o[1], 64'd25);

        // Atomic 64-bit write near the top, then wrap.
        wr(ADDR_MTIME_LO, 32'hFFFF_FFFE);
        wr(ADDR_MTIME_HI, 32'hFFFF_FFFF);
        check("wrap commit", mtime_o[0], 64'hFFFF_FFFF_FFFF_FFFE);
        idle(1);
        check("wrap max", mtime_o[0], 64'hFFFF_FFFF_FFFF_FFFF);
        idle(1);
        check("wrap zero", mtime_o[0], 64'h0);

        // Interrupt against a small deadline.
        do_reset();
        wr(ADDR_CMP_LO, 32'd5);
        wr(ADDR_CMP_HI, 32'd0);
        wr(ADDR_CTRL, 32'h1);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mtime_o[0] == 64'd5) begin
                found = 1'b1;
                break;
            end
            idle(1);
        end
        check("mtime reached 5", 64'(found), 64'h1);
        check("irq low as mtime hits cmp", 64'(irq[0]), 64'h0);
        idle(1);
        check("irq rises", 64'(irq[0]), 64'h1);
        idle(3);
        check("irq stays high", 64'(irq[0]), 64'h1);
        wr(ADDR_CMP_HI, 32'd1);
        idle(1);
        check("irq drops after CMP_HI=1", 64'(irq[0]), 64'h0);

        // Staging aborted by an intervening read.
        wr(ADDR_CMP_LO, 32'd7);
        rd(ADDR_CTRL);
        wr(ADDR_CMP_HI, 32'd0);
        rd(ADDR_CMP_LO);
        check("aborted staging keeps old low", 64'(rsp_rdata[0]), 64'd5);
        rd(ADDR_CMP_HI);

        // Snapshot of the high word across a carry.
        wr(ADDR_MTIME_LO, 32'hFFFF_FFFF);
        wr(ADDR_MTIME_HI, 32'h1);
        rd(ADDR_MTIME_LO);
        check("read lo before carry", 64'(rsp_rdata[0]), 64'hFFFF_FFFF);
        idle(3);
        rd(ADDR_MTIME_HI);
        check("read hi from snapshot", 64'(rsp_rdata[0]), 64'h1);
        check("mtime carried", 64'(mtime_o[0][63:32]), 64'h2);

        // Reset between LO and HI writes.
        wr(ADDR_MTIME_LO, 32'h1234_5678);
        do_reset();
        wr(ADDR_MTIME_HI, 32'hAB);
        check("hi after reset uses low 0", mtime_o[0], {32'hAB, 32'h0});
        rd(ADDR_CMP_LO);
        rd(ADDR_CTRL);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            v  = ($urandom_range(0, 9) < 7);
            we = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 6))
                0: a = ADDR_MTIME_LO;
                1: a = ADDR_MTIME_HI;
                2: a = ADDR_CMP_LO;
                3: a = ADDR_CMP_HI;
                4: a = 5'($urandom_range(0, 31));
                default: a = ADDR_CTRL;
            endcase
            if (a == ADDR_CTRL) wd = 32'($urandom_range(0, 3) != 0);
            else if ($urandom_range(0, 3) == 0) wd = $urandom;
            else wd = 32'($urandom_range(0, 60));
            do_cycle(v, we, a, wd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
